pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Parametrised, elastic pipeline stage register for the RV32I pipeline with a valid/ready handshake, a one-entry skid buffer, flush, and bubble insertion. One instance sits at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries that boundary's packed payload: control word plus data fields. Stalls are absorbed locally, so the upstream ready signal is a function of registered state only and never a combinational path from downstream. Flushed or empty slots present a configurable bubble value, the RV32I NOP for instruction-carrying stages.

## Interface
- WIDTH, 32: payload width in bits, >= 1.
- BUBBLE, {WIDTH{1'b0}}: value driven on out_data whenever out_valid = 0; set to 32'h00000013 for IF/ID.
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset, synchronous and active-low.
- flush  input  1  discard all held entries this cycle.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  stage accepts a payload this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a real payload.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  payload to downstream, or BUBBLE.
- occupancy  output  2  entries held: 0, 1 or 2.

## Operation
- Storage: main register (drives out_data) and skid register, each with a valid bit.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State machine:
  - EMPTY (occupancy 0, in_ready 1, out_valid 0).
  - ONE (occupancy 1, in_ready 1, out_valid 1).
  - FULL (occupancy 2, in_ready 0, out_valid 1).
- Transitions when flush = 0:
  - EMPTY: in_fire -> ONE, main <= in_data; otherwise stay in EMPTY.
  - ONE:
    - in_fire & out_fire -> ONE, main <= in_data.
    - in_fire & !out_fire -> FULL, skid <= in_data.
    - !in_fire & out_fire -> EMPTY.
    - Neither -> hold.
  - FULL: out_fire -> ONE, main <= skid. Otherwise hold. No in_fire is possible in FULL.
- flush = 1, highest priority:
  - Next state is EMPTY. Both valid bits clear.
  - in_data offered this cycle is dropped, even though in_ready may read 1.
  - An out_fire in the same cycle is a legal transfer; the downstream consumes it.
- rst_n = 0 at posedge: next state is EMPTY. Payload registers need not clear. rst_n dominates flush and all handshakes.
- Outputs are pure functions of registered state:
  - out_data = main when out_valid, else BUBBLE.
  - in_ready = (state != FULL).
  - occupancy is encoded from state.
- Payload is never modified, reordered, or duplicated. Order is FIFO: main before skid.
- Data registers load only on the transitions listed above. They hold otherwise, so there is no toggling under stall.

## Timing
- Latency: in_fire at edge N gives out_valid = 1 with that payload after edge N; it is first consumable in cycle N+1.
- Throughput: 1 payload/cycle sustained while out_ready = 1.
- in_ready drops in the cycle after the first unabsorbed stall. The one payload accepted in that stall cycle lands in skid, so no data is lost.
- After reset: outputs are out_valid = 0, in_ready = 1, occupancy = 0, out_data = BUBBLE, from the first cycle following the reset edge until new state.
- Flush and reset take effect at the edge. Outputs show EMPTY in the next cycle.
- No combinational path from out_ready or flush to in_ready, out_valid, or out_data.

## Structure
- The state enum pipe_state_t {PS_EMPTY, PS_ONE, PS_FULL} goes into package rv32i_types.
- The NOP constant 32'h00000013 goes into rv32i_types as RV32I_NOP and is passed as BUBBLE.
- Control-word payloads are packed via $bits(rv32i_control_word) at the instantiation site.
- One sub-module, pipe_dreg: WIDTH-bit register with load enable and no reset. Instantiated twice (main, skid).

## Test plan
All scenarios use WIDTH = 32, BUBBLE = 32'h13.
1. Reset, then idle:
   - Stimulus: rst_n = 0 for 2 cycles, then release with in_valid = 0.
   - Response: out_valid = 0, out_data = 32'h13, in_ready = 1, occupancy = 0.
2. Streaming:
   - Stimulus: out_ready = 1; send 32'hA0..32'hA7 on consecutive cycles.
   - Response: the same sequence appears on out_data one cycle later, with no gaps and in_ready constantly 1.
3. Stall absorb:
   - Stimulus: send 32'hB0, 32'hB1, 32'hB2 back-to-back, with out_ready = 0 from the cycle B0 becomes visible.
   - Response:
     - B1 is accepted into skid; occupancy = 2; in_ready = 0; B2 is held upstream.
     - On out_ready = 1, the outputs are B0, B1, B2 in order.
4. Flush while FULL:
   - Stimulus: occupancy = 2 holding 32'hC0 and 32'hC1; assert flush with in_valid = 1, in_data = 32'hC2.
   - Response: next cycle occupancy = 0, out_data = 32'h13, and C2 never appears.
5. Flush with a simultaneous out_fire:
   - Stimulus: in ONE holding 32'hD0, out_ready = 1 and flush = 1 together.
   - Response: D0 is counted as transferred; the next cycle is EMPTY.
6. Reset mid-operation:
   - Stimulus: in FULL, rst_n = 0 together with flush = 0 and out_ready = 1.
   - Response: EMPTY next cycle, in_ready = 1, and no stale payload ever becomes visible.

Source files
------------

// File: rtl/pipe_skid_stage_pkg.sv
// Shared RV32I pipeline types: stage-register states, the NOP bubble value,
// and the control word that rides along each stage boundary.
package rv32i_types;

  // Occupancy states of an elastic stage register.
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_t;

  // addi x0, x0, 0 -- shown in instruction-carrying stages when empty.
  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

  // Control word; instantiation sites size payloads with $bits() of this.
  typedef struct packed {
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic       jump;
    logic [3:0] aluOp;
    logic [1:0] wbSel;
  } rv32i_control_word;

  // Number of payloads held in a given state.
  function automatic logic [1:0] occupancyOf(input pipe_state_t state);
    case (state)
      PS_EMPTY: occupancyOf = 2'd0;
      PS_ONE:   occupancyOf = 2'd1;
      PS_FULL:  occupancyOf = 2'd2;
      default:  occupancyOf = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_stage_dreg.sv
// Plain payload register with load enable; no reset because validity is
// tracked separately by the stage state machine.
module pipe_dreg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Capture only when asked, so a stalled payload never toggles.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage register: main register feeding downstream plus a
// one-entry skid register, so upstream ready depends only on local state.
module pipe_skid_stage
  import rv32i_types::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  pipe_state_t      r_state;
  pipe_state_t      w_nextState;
  logic             r_inReady;
  logic             r_outValid;
  logic [1:0]       r_occupancy;

  logic             w_inFire;
  logic             w_outFire;
  logic             w_loadMain;
  logic             w_loadSkid;
  logic [WIDTH-1:0] w_mainD;
  logic [WIDTH-1:0] w_mainQ;
  logic [WIDTH-1:0] w_skidQ;

  assign w_inFire  = in_valid & r_inReady;
  assign w_outFire = r_outValid & out_ready;

  // Next state and register load enables; reset and flush empty the stage
  // and suppress every load, dropping whatever was offered this cycle.
  always_comb begin
    w_nextState = r_state;
    w_loadMain  = 1'b0;
    w_loadSkid  = 1'b0;
    w_mainD     = in_data;
    if (!rst_n || flush) begin
      w_nextState = PS_EMPTY;
    end else begin
      case (r_state)
        PS_EMPTY: begin
          if (w_inFire) begin
            w_nextState = PS_ONE;
            w_loadMain  = 1'b1;
          end
        end
        PS_ONE: begin
          if (w_inFire && w_outFire) begin
            w_loadMain = 1'b1;
          end else if (w_inFire) begin
            w_nextState = PS_FULL;
            w_loadSkid  = 1'b1;
          end else if (w_outFire) begin
            w_nextState = PS_EMPTY;
          end
        end
        PS_FULL: begin
          if (w_outFire) begin
            w_nextState = PS_ONE;
            w_loadMain  = 1'b1;
            w_mainD     = w_skidQ;
          end
        end
        default: begin
          w_nextState = PS_EMPTY;
        end
      endcase
    end
  end

  // State register with handshake outputs registered from the next state,
  // keeping out_ready and flush off any combinational output path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= PS_EMPTY;
      r_inReady   <= 1'b1;
      r_outValid  <= 1'b0;
      r_occupancy <= 2'd0;
    end else begin
      r_state     <= w_nextState;
      r_inReady   <= (w_nextState != PS_FULL);
      r_outValid  <= (w_nextState != PS_EMPTY);
      r_occupancy <= occupancyOf(w_nextState);
    end
  end

  pipe_dreg #(.WIDTH(WIDTH)) u_mainReg (
    .clk    (clk),
    .i_load (w_loadMain),
    .i_d    (w_mainD),
    .o_q    (w_mainQ)
  );

  pipe_dreg #(.WIDTH(WIDTH)) u_skidReg (
    .clk    (clk),
    .i_load (w_loadSkid),
    .i_d    (in_data),
    .o_q    (w_skidQ)
  );

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign occupancy = r_occupancy;
  assign out_data  = r_outValid ? w_mainQ : BUBBLE;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios followed by
// random traffic, all compared against a two-deep FIFO reference model.
module tb_pipe_skid_stage;
  import rv32i_types::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  int compared   = 0;
  int mismatched = 0;

  // Reference contents of the stage, oldest first.
  logic [WIDTH-1:0] model[$];

  // Free-running clock.
  always #5 clk = ~clk;

  pipe_skid_stage #(
    .WIDTH  (WIDTH),
    .BUBBLE (RV32I_NOP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Compare every visible output with what the queue model implies.
  task automatic checkAll(input string ctx);
    int n;
    logic [31:0] expData;
    n = model.size();
    expData = (n > 0) ? model[0] : RV32I_NOP;
    checkOutput({ctx, " out_valid"}, {31'd0, out_valid}, (n > 0) ? 32'd1 : 32'd0);
    checkOutput({ctx, " out_data"},  out_data, expData);
    checkOutput({ctx, " in_ready"},  {31'd0, in_ready}, (n < 2) ? 32'd1 : 32'd0);
    checkOutput({ctx, " occupancy"}, {30'd0, occupancy}, n);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check.
  task automatic applyStimulus(input logic r, input logic f, input logic iv,
                               input logic [31:0] id, input logic ordy,
                               input string ctx);
    bit inFire;
    bit outFire;
    rst_n     = r;
    flush     = f;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    inFire  = iv && (model.size() < 2);
    outFire = (model.size() > 0) && ordy;
    @(posedge clk);
    #1;
    if (!r || f) begin
      model.delete();
    end else begin
      if (outFire) void'(model.pop_front());
      if (inFire) model.push_back(id);
    end
    checkAll(ctx);
  endtask

  initial begin
    logic [31:0] rv;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;

    // Reset then idle.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "reset1");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "reset2");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, "idle");

    // Streaming A0..A7 with downstream always ready.
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, 32'hA0 + i, 1'b1, "stream");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, "streamDrain");

    // Stall absorb: B1 lands in skid, B2 held upstream until space frees.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hB0, 1'b1, "stallB0");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hB1, 1'b0, "stallB1");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hB2, 1'b0, "stallHold");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hB2, 1'b1, "stallRel1");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hB2, 1'b1, "stallRel2");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, "stallRel3");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, "stallRel4");

    // Flush while FULL with C2 offered: C2 must never appear.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hC0, 1'b0, "fillC0");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hC1, 1'b0, "fillC1");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hC2, 1'b0, "flushFull");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hC2, 1'b1, "afterFlush");

    // Flush together with an out_fire of D0.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hD0, 1'b0, "loadD0");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0,  1'b1, "flushFire");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, "afterFlushFire");

    // Reset while FULL: nothing stale may surface afterwards.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hE0, 1'b0, "fillE0");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hE1, 1'b0, "fillE1");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, "resetFull");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, "afterReset");

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      rv = $urandom;
      applyStimulus(($urandom_range(0, 49) != 0),
                    ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 3) != 0),
                    rv,
                    ($urandom_range(0, 2) != 0),
                    "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
